tile_order_reader: RTL and testbench

TILE_ORDER_READER -- requirements
Module: tile_order_reader

---
 rtl/tile_order_reader_if.sv | 23 ++
 rtl/tile_order_reader.sv | 120 ++++++++++++
 tb/tb_tile_order_reader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_order_reader_if.sv
// Lookup request/response channel for tile_order_reader.
// The master issues slot lookups; the slave (the reader) answers one cycle later.
interface tile_order_reader_if #(
    parameter int TW = 5
);
    logic          req_valid;
    logic          req_ready;
    logic          req_ring;
    logic [TW-1:0] req_pos;
    logic          rsp_valid;
    logic [TW-1:0] rsp_tile;
    logic          rsp_err;

    modport master (
        output req_valid, req_ring, req_pos,
        input  req_ready, rsp_valid, rsp_tile, rsp_err
    );

    modport slave (
        input  req_valid, req_ring, req_pos,
        output req_ready, rsp_valid, rsp_tile, rsp_err
    );
endinterface

// File: rtl/tile_order_reader.sv
// Captures an edge-ring and center tile order, checks each is a permutation
// one slot per cycle, then serves slot lookups while the order is legal.
module tile_order_reader #(
    parameter int EDGE_N   = 24,
    parameter int CENTER_N = 12,
    parameter int TW       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [EDGE_N*TW-1:0]   edge_order_in,
    input  logic [CENTER_N*TW-1:0] center_order_in,
    output logic                   busy,
    output logic                   order_valid,
    output logic                   order_error,
    tile_order_reader_if.slave     req_if
);
    localparam int              DEPTH     = 2**TW;
    localparam logic [TW:0]     EDGE_LIM  = (TW+1)'(EDGE_N);
    localparam logic [TW:0]     CEN_LIM   = (TW+1)'(CENTER_N);
    localparam logic [TW-1:0]   EDGE_LAST = TW'(EDGE_N - 1);
    localparam logic [TW-1:0]   CEN_LAST  = TW'(CENTER_N - 1);

    typedef enum logic [1:0] {EMPTY, CHECK, READY, ERROR} state_t;

    state_t            state;
    logic [TW-1:0]     edge_mem   [DEPTH];
    logic [TW-1:0]     center_mem [DEPTH];
    logic [DEPTH-1:0]  edge_seen;
    logic [DEPTH-1:0]  center_seen;
    logic              err_flag;
    logic              phase;
    logic [TW-1:0]     slot;
    logic [TW-1:0]     cur_id;
    logic              cur_bad;
    logic              req_fire;
    logic              rsp_valid_q;
    logic [TW-1:0]     rsp_tile_q;
    logic              rsp_err_q;

    // Storage is padded to 2**TW entries so any TW-bit ID or position indexes
    // it safely; entries past the ring size stay zero and are never reported.
    always_comb begin
        cur_id  = phase ? center_mem[slot] : edge_mem[slot];
        cur_bad = 1'b0;
        if (phase)
            cur_bad = ({1'b0, cur_id} >= CEN_LIM) || center_seen[cur_id];
        else
            cur_bad = ({1'b0, cur_id} >= EDGE_LIM) || edge_seen[cur_id];
    end

    assign busy             = (state == CHECK);
    assign order_valid      = (state == READY);
    assign order_error      = (state == ERROR);
    assign req_if.req_ready = (state == READY) && !load;
    assign req_fire         = req_if.req_valid && req_if.req_ready;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_tile  = rsp_tile_q;
    assign req_if.rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            edge_mem    <= '{default: '0};
            center_mem  <= '{default: '0};
            edge_seen   <= '0;
            center_seen <= '0;
            err_flag    <= 1'b0;
            phase       <= 1'b0;
            slot        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tile_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= req_fire;
            if (req_fire) begin
                if (!req_if.req_ring && ({1'b0, req_if.req_pos} < EDGE_LIM)) begin
                    rsp_tile_q <= edge_mem[req_if.req_pos];
                    rsp_err_q  <= 1'b0;
                end else if (req_if.req_ring && ({1'b0, req_if.req_pos} < CEN_LIM)) begin
                    rsp_tile_q <= center_mem[req_if.req_pos];
                    rsp_err_q  <= 1'b0;
                end else begin
                    rsp_tile_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end

            if (load) begin
                for (int unsigned k = 0; k < EDGE_N; k++)
                    edge_mem[k] <= edge_order_in[k*TW +: TW];
                for (int unsigned k = 0; k < CENTER_N; k++)
                    center_mem[k] <= center_order_in[k*TW +: TW];
                edge_seen   <= '0;
                center_seen <= '0;
                err_flag    <= 1'b0;
                phase       <= 1'b0;
                slot        <= '0;
                state       <= CHECK;
            end else if (state == CHECK) begin
                if (cur_bad)
                    err_flag <= 1'b1;
                else if (phase)
                    center_seen[cur_id] <= 1'b1;
                else
                    edge_seen[cur_id] <= 1'b1;

                // The final verdict folds in the slot examined on this same edge.
                if (!phase && slot == EDGE_LAST) begin
                    phase <= 1'b1;
                    slot  <= '0;
                end else if (phase && slot == CEN_LAST) begin
                    state <= (err_flag || cur_bad) ? ERROR : READY;
                end else begin
                    slot <= slot + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tile_order_reader.sv
// Directed bench for tile_order_reader: a cycle-level order model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_tile_order_reader;
    localparam int EDGE_N   = 24;
    localparam int CENTER_N = 12;
    localparam int TW       = 5;
    localparam int CHK_LAT  = EDGE_N + CENTER_N;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   load = 1'b0;
    logic [EDGE_N*TW-1:0]   edge_vec = '0;
    logic [CENTER_N*TW-1:0] cen_vec = '0;
    logic                   busy, order_valid, order_error;

    tile_order_reader_if #(.TW(TW)) bus ();

    tile_order_reader #(.EDGE_N(EDGE_N), .CENTER_N(CENTER_N), .TW(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .edge_order_in   (edge_vec),
        .center_order_in (cen_vec),
        .busy            (busy),
        .order_valid     (order_valid),
        .order_error     (order_error),
        .req_if          (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // An order is legal when every ID is in range and no ID repeats in its ring.
    function automatic bit order_legal(input logic [EDGE_N*TW-1:0] ev,
                                       input logic [CENTER_N*TW-1:0] cv);
        int cnt_e[32];
        int cnt_c[32];
        int id;
        for (int i = 0; i < 32; i++) begin
            cnt_e[i] = 0;
            cnt_c[i] = 0;
        end
        for (int k = 0; k < EDGE_N; k++) begin
            id = int'(ev[k*TW +: TW]);
            if (id >= EDGE_N) return 1'b0;
            cnt_e[id]++;
            if (cnt_e[id] > 1) return 1'b0;
        end
        for (int k = 0; k < CENTER_N; k++) begin
            id = int'(cv[k*TW +: TW]);
            if (id >= CENTER_N) return 1'b0;
            cnt_c[id]++;
            if (cnt_c[id] > 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Model state: time of last load, verdict, stored order, response registers.
    int  cyc = 0;
    int  m_load_cyc = 0;
    bit  m_have = 1'b0;
    bit  m_legal = 1'b0;
    bit  chk_en = 1'b0;
    int  m_edge[32];
    int  m_cen[32];
    bit  m_rsp_valid = 1'b0;
    int  m_rsp_tile = 0;
    bit  m_rsp_err = 1'b0;
    bit  m_acc;
    int  m_el;
    int  c_el;
    int  p;

    always @(posedge clk) begin
        m_el  = cyc - m_load_cyc;
        m_acc = m_have && m_legal && (m_el >= CHK_LAT) && !load && bus.req_valid;
        cyc++;
        if (rst) begin
            chk_en      = 1'b1;
            m_have      = 1'b0;
            m_rsp_valid = 1'b0;
            m_rsp_tile  = 0;
            m_rsp_err   = 1'b0;
            for (int i = 0; i < 32; i++) begin
                m_edge[i] = 0;
                m_cen[i]  = 0;
            end
        end else begin
            m_rsp_valid = m_acc;
            if (m_acc) begin
                p = int'(bus.req_pos);
                if (!bus.req_ring && p < EDGE_N) begin
                    m_rsp_tile = m_edge[p]; m_rsp_err = 1'b0;
                end else if (bus.req_ring && p < CENTER_N) begin
                    m_rsp_tile = m_cen[p]; m_rsp_err = 1'b0;
                end else begin
                    m_rsp_tile = 0; m_rsp_err = 1'b1;
                end
            end
            if (load) begin
                m_have     = 1'b1;
                m_load_cyc = cyc;
                m_legal    = order_legal(edge_vec, cen_vec);
                for (int k = 0; k < EDGE_N; k++) m_edge[k] = int'(edge_vec[k*TW +: TW]);
                for (int k = 0; k < CENTER_N; k++) m_cen[k] = int'(cen_vec[k*TW +: TW]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            c_el = cyc - m_load_cyc;
            chk("busy",        busy,          m_have && c_el < CHK_LAT);
            chk("order_valid", order_valid,   m_have && c_el >= CHK_LAT && m_legal);
            chk("order_error", order_error,   m_have && c_el >= CHK_LAT && !m_legal);
            chk("req_ready",   bus.req_ready, m_have && c_el >= CHK_LAT && m_legal && !load);
            chk("rsp_valid",   bus.rsp_valid, m_rsp_valid);
            chk("rsp_tile",    bus.rsp_tile,  m_rsp_tile);
            chk("rsp_err",     bus.rsp_err,   m_rsp_err);
        end
    end

    int e_ord[EDGE_N];
    int c_ord[CENTER_N];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic identity();
        for (int k = 0; k < EDGE_N; k++) e_ord[k] = k;
        for (int k = 0; k < CENTER_N; k++) c_ord[k] = k;
    endtask

    task automatic pack();
        for (int k = 0; k < EDGE_N; k++) edge_vec[k*TW +: TW] = TW'(e_ord[k]);
        for (int k = 0; k < CENTER_N; k++) cen_vec[k*TW +: TW] = TW'(c_ord[k]);
    endtask

    task automatic do_load();
        pack();
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    // Load edge already passed; verify busy right before and verdict at latency.
    task automatic finish_check(input string tag, input bit legal);
        step(CHK_LAT - 1);
        chk({tag, "_busy_last"}, busy, 1'b1);
        step(1);
        chk({tag, "_valid"}, order_valid, legal);
        chk({tag, "_error"}, order_error, !legal);
        chk({tag, "_ready"}, bus.req_ready, legal);
    endtask

    task automatic lookup(input logic ring, input int pos, input int exp_tile, input bit exp_err);
        bus.req_valid = 1'b1;
        bus.req_ring  = ring;
        bus.req_pos   = TW'(pos);
        step(1);
        bus.req_valid = 1'b0;
        chk("lit_rsp_valid", bus.rsp_valid, 1'b1);
        chk("lit_rsp_tile",  bus.rsp_tile,  exp_tile);
        chk("lit_rsp_err",   bus.rsp_err,   exp_err);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_ring  = 1'b0;
        bus.req_pos   = '0;
        step(2);
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_tile", bus.rsp_tile, 0);

        identity();
        pack();
        chk("model_identity_legal", order_legal(edge_vec, cen_vec), 1'b1);
        do_load();
        finish_check("ident", 1'b1);
        lookup(1'b0, 5, 5, 1'b0);
        step(1);
        chk("rsp_one_cycle", bus.rsp_valid, 1'b0);
        chk("rsp_hold_tile", bus.rsp_tile, 5);

        lookup(1'b0, 0, 0, 1'b0);
        lookup(1'b0, 1, 1, 1'b0);
        lookup(1'b0, 2, 2, 1'b0);
        lookup(1'b0, 24, 0, 1'b1);
        lookup(1'b1, 12, 0, 1'b1);
        lookup(1'b1, 3, 3, 1'b0);
        lookup(1'b0, 23, 23, 1'b0);

        load = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_pos = TW'(7);
        #1;
        chk("load_blocks_ready", bus.req_ready, 1'b0);
        step(1);
        load = 1'b0;
        bus.req_valid = 1'b0;
        chk("load_wins_busy", busy, 1'b1);
        chk("load_wins_no_rsp", bus.rsp_valid, 1'b0);
        finish_check("reload", 1'b1);

        identity();
        e_ord[3] = 9;
        e_ord[17] = 9;
        pack();
        chk("model_dup_illegal", order_legal(edge_vec, cen_vec), 1'b0);
        do_load();
        finish_check("dup", 1'b0);
        bus.req_valid = 1'b1;
        bus.req_pos = '0;
        step(1);
        bus.req_valid = 1'b0;
        chk("error_no_rsp", bus.rsp_valid, 1'b0);

        identity();
        e_ord[0] = 30;
        do_load();
        finish_check("edge_range", 1'b0);

        identity();
        c_ord[11] = 12;
        do_load();
        finish_check("cen_range", 1'b0);

        identity();
        for (int k = 0; k < CENTER_N; k++) c_ord[k] = CENTER_N - 1 - k;
        do_load();
        finish_check("cen_rev", 1'b1);
        lookup(1'b1, 0, 11, 1'b0);

        identity();
        e_ord[2] = 4;
        do_load();
        step(19);
        identity();
        do_load();
        for (int k = 0; k < EDGE_N; k++) e_ord[k] = 31;
        pack();
        finish_check("abort", 1'b1);
        lookup(1'b0, 23, 23, 1'b0);

        identity();
        do_load();
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", order_valid, 1'b0);
        chk("midrst_error", order_error, 1'b0);
        chk("midrst_rsp_tile", bus.rsp_tile, 0);
        step(CHK_LAT + 4);
        chk("midrst_no_verdict", order_valid | order_error, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
